// File: rtl/wshb_pkg.sv
// wshb_pkg
//   Shared definitions for the Wishbone video stream sink.
//   - CTI_* : Wishbone B4 cycle type identifiers used by the stream bus.
//   - pix_word_t : one buffered pixel word plus its start-of-frame tag.
//   - apply_sel : zeroes every byte lane whose select bit is low.
package wshb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } pix_word_t;

    // Unselected byte lanes are stored as zero rather than left stale.
    function automatic logic [31:0] apply_sel(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo
//   Synchronous first-word-fall-through FIFO with asynchronous active-high reset.
//   Ports:
//     sys_clk, sys_rst : clock and asynchronous reset (clears pointers and level)
//     push, push_data  : write one entry; ignored when the FIFO is full
//     pop              : drop the head entry; ignored when the FIFO is empty
//     head             : current head entry, valid whenever empty is low
//     empty            : no entries stored
//     level            : occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo
    import wshb_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = pix_word_t
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (level != FULL_LVL);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: an entry is only visible once level covers it.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; level tracks occupancy so full and empty are unambiguous.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wshb_stream_sink.sv
// wshb_stream_sink
//   Wishbone B4 slave that terminates the video stream bus. Pixel-word writes
//   are buffered in a FWFT FIFO and presented on a valid/ready stream port.
//   The word written to address 0 is tagged as start-of-frame. Reads get err.
//   Ports:
//     sys_clk, sys_rst        : clock, asynchronous active-high reset
//     cyc, stb, we, adr       : Wishbone request; adr==0 marks start of frame
//     dat_ms, sel             : write data and byte selects
//     cti, bte                : cycle type (classic / incr / end of burst); bte ignored
//     ack, err                : registered write acknowledge / read refusal
//     rty, dat_sm             : tied to zero
//     out_data, out_sof       : head-of-FIFO pixel word and its frame tag
//     out_valid, out_ready    : stream handshake, pop on valid & ready
//     level                   : FIFO occupancy
module wshb_stream_sink
    import wshb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ADR_W = 32
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic                   we,
    input  logic [ADR_W-1:0]       adr,
    input  logic [31:0]            dat_ms,
    input  logic [3:0]             sel,
    input  logic [2:0]             cti,
    input  logic [1:0]             bte,
    output logic                   ack,
    output logic                   err,
    output logic                   rty,
    output logic [31:0]            dat_sm,
    output logic [31:0]            out_data,
    output logic                   out_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int             LVL_W     = $clog2(DEPTH) + 1;
    localparam logic [LVL_W:0] DEPTH_EXT = (LVL_W + 1)'(DEPTH);

    logic           req;
    logic           space;
    logic           ack_d;
    logic           err_d;
    logic           pop;
    logic           fifo_empty;
    logic [LVL_W:0] committed;
    pix_word_t      push_word;
    pix_word_t      head_word;
    logic           unused_bte;

    // Only linear bursts exist on this bus, so the burst type is not decoded.
    assign unused_bte = ^bte;

    assign req = cyc & stb;

    // The word being acked this cycle lands at the next edge, so it already
    // occupies a slot when deciding whether the following word may be acked.
    assign committed = {1'b0, level} + {{LVL_W{1'b0}}, ack};
    assign space     = committed < DEPTH_EXT;

    // Classic cycles get one ack and a gap; incrementing bursts may stream
    // acks back to back; an end-of-burst word receives its ack and stops.
    assign ack_d = req & we & space & (~ack | (cti == CTI_INCR));
    assign err_d = req & ~we & ~err;

    always_comb begin
        push_word.sof  = (adr == {ADR_W{1'b0}});
        push_word.data = apply_sel(dat_ms, sel);
    end

    // Registered handshake; reset drops any transfer in flight without an ack.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack <= 1'b0;
            err <= 1'b0;
        end else begin
            ack <= ack_d;
            err <= err_d;
        end
    end

    assign pop = out_valid & out_ready;

    stream_fifo #(
        .DEPTH (DEPTH),
        .T     (pix_word_t)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (ack),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_word.data;
    assign out_sof   = head_word.sof;
    assign rty       = 1'b0;
    assign dat_sm    = 32'h0000_0000;

endmodule
